// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle arithmetic/logic ops, iterative multiply and divide,
// with results returned to EX/MEM on a valid/ready handshake.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             branch_taken,
  output logic             mem_src,
  output logic             div_by_zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_MUL    = 4'h2;
  localparam logic [3:0] OP_DIV    = 4'h3;
  localparam logic [3:0] OP_MOVE   = 4'h4;
  localparam logic [3:0] OP_SWAP   = 4'h5;
  localparam logic [3:0] OP_AND    = 4'h6;
  localparam logic [3:0] OP_OR     = 4'h7;
  localparam logic [3:0] OP_LDST   = 4'h8;
  localparam logic [3:0] OP_BRANCH = 4'h9;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   resultHi_q, resultHi_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               branch_q, branch_d;
  logic               memSrc_q, memSrc_d;
  logic               divZero_q, divZero_d;
  logic               illegal_q, illegal_d;

  logic [3:0]         opCode;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   scResult, scHi;
  logic               scCarry, scBranch, scIllegal;
  logic [WIDTH:0]     mulSum, divShift, divTrial;
  logic [2*WIDTH-1:0] mulNext, divNext;

  assign opCode = control[3:0];

  // Results of every operation that finishes on the accept edge
  always_comb begin
    sum       = {1'b0, op_a} + {1'b0, op_b};
    diff      = {1'b0, op_a} - {1'b0, op_b};
    scResult  = '0;
    scHi      = '0;
    scCarry   = 1'b0;
    scBranch  = 1'b0;
    scIllegal = 1'b0;
    case (opCode)
      OP_ADD, OP_LDST: begin
        scResult = sum[WIDTH-1:0];
        scCarry  = sum[WIDTH];
      end
      OP_SUB: begin
        scResult = diff[WIDTH-1:0];
        scCarry  = diff[WIDTH];
      end
      OP_MOVE: scResult = op_b;
      OP_SWAP: begin
        scResult = op_b;
        scHi     = op_a;
      end
      OP_AND: scResult = op_a & op_b;
      OP_OR:  scResult = op_a | op_b;
      OP_BRANCH: begin
        scResult = diff[WIDTH-1:0];
        scBranch = (op_a == op_b);
      end
      OP_DIV: begin
        scResult = '1;
        scHi     = op_a;
      end
      OP_MUL: scResult = '0;
      default: scIllegal = 1'b1;
    endcase
  end

  // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient/dividend}
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, operand_q};
    mulNext  = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:1]};
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divTrial = divShift - {1'b0, operand_q};
    divNext  = divTrial[WIDTH] ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    result_d   = result_q;
    resultHi_d = resultHi_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    branch_d   = branch_q;
    memSrc_d   = memSrc_q;
    divZero_d  = divZero_q;
    illegal_d  = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          memSrc_d  = control[4];
          carry_d   = 1'b0;
          branch_d  = 1'b0;
          divZero_d = 1'b0;
          illegal_d = 1'b0;
          count_d   = CW'(WIDTH);
          if (opCode == OP_MUL) begin
            state_d   = MUL;
            operand_d = op_a;
            acc_d     = {{WIDTH{1'b0}}, op_b};
          end else if (opCode == OP_DIV && op_b != '0) begin
            state_d   = DIV;
            operand_d = op_b;
            acc_d     = {{WIDTH{1'b0}}, op_a};
          end else begin
            state_d    = DONE;
            result_d   = scResult;
            resultHi_d = scHi;
            carry_d    = scCarry;
            branch_d   = scBranch;
            illegal_d  = scIllegal;
            divZero_d  = (opCode == OP_DIV);
            zero_d     = (scResult == '0);
          end
        end
      end
      MUL: begin
        acc_d   = mulNext;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d    = DONE;
          result_d   = mulNext[WIDTH-1:0];
          resultHi_d = mulNext[2*WIDTH-1:WIDTH];
          zero_d     = (mulNext[WIDTH-1:0] == '0);
        end
      end
      DIV: begin
        acc_d   = divNext;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d    = DONE;
          result_d   = divNext[WIDTH-1:0];
          resultHi_d = divNext[2*WIDTH-1:WIDTH];
          zero_d     = (divNext[WIDTH-1:0] == '0);
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      operand_q  <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      resultHi_q <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      branch_q   <= 1'b0;
      memSrc_q   <= 1'b0;
      divZero_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      resultHi_q <= resultHi_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      branch_q   <= branch_d;
      memSrc_q   <= memSrc_d;
      divZero_q  <= divZero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign result       = result_q;
  assign result_hi    = resultHi_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign branch_taken = branch_q;
  assign mem_src      = memSrc_q;
  assign div_by_zero  = divZero_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=16) with hand-computed expected values.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  control;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        carry;
  logic        zero;
  logic        branch_taken;
  logic        mem_src;
  logic        div_by_zero;
  logic        illegal;

  int tests;
  int failures;
  int cycles;
  int strayValid;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .control(control),
    .op_a(op_a),
    .op_b(op_b),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .result_hi(result_hi),
    .carry(carry),
    .zero(zero),
    .branch_taken(branch_taken),
    .mem_src(mem_src),
    .div_by_zero(div_by_zero),
    .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one operation for a single accept edge, then returns #1 after that edge
  task automatic applyStimulus(input logic [4:0] ctrl, input logic [15:0] a, input logic [15:0] b);
    control  = ctrl;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counted as in the datapath docs: out_valid right after the accept edge is 1 cycle
  task automatic waitValid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests      = 0;
    failures   = 0;
    strayValid = 0;
    rst_n      = 1'b0;
    control    = '0;
    op_a       = '0;
    op_b       = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;

    #3;
    checkOutput("reset in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset out_valid", 16'(out_valid), 16'd0);
    checkOutput("reset result", result, 16'h0000);
    checkOutput("reset zero", 16'(zero), 16'd0);
    #4 rst_n = 1'b1;
    stepCycle();

    // Add with carry out and zero result
    applyStimulus(5'b00000, 16'hFFFF, 16'h0001);
    checkOutput("add out_valid", 16'(out_valid), 16'd1);
    checkOutput("add result", result, 16'h0000);
    checkOutput("add carry", 16'(carry), 16'd1);
    checkOutput("add zero", 16'(zero), 16'd1);
    stepCycle();
    checkOutput("add leave DONE", 16'(in_ready), 16'd1);

    applyStimulus(5'b00001, 16'h0003, 16'h0005);
    checkOutput("sub result", result, 16'hFFFE);
    checkOutput("sub borrow", 16'(carry), 16'd1);
    checkOutput("sub zero", 16'(zero), 16'd0);
    stepCycle();

    applyStimulus(5'b00110, 16'h00F0, 16'h0FF0);
    checkOutput("and result", result, 16'h00F0);
    stepCycle();
    applyStimulus(5'b00111, 16'h00F0, 16'h0F0F);
    checkOutput("or result", result, 16'h0FFF);
    stepCycle();
    applyStimulus(5'b00100, 16'h1111, 16'h2222);
    checkOutput("move result", result, 16'h2222);
    checkOutput("move hi", result_hi, 16'h0000);
    stepCycle();
    applyStimulus(5'b11000, 16'h8000, 16'h8001);
    checkOutput("ldst result", result, 16'h0001);
    checkOutput("ldst carry", 16'(carry), 16'd1);
    checkOutput("ldst mem_src", 16'(mem_src), 16'd1);
    stepCycle();

    applyStimulus(5'b10101, 16'h00AA, 16'h0055);
    checkOutput("swap result", result, 16'h0055);
    checkOutput("swap hi", result_hi, 16'h00AA);
    checkOutput("swap mem_src", 16'(mem_src), 16'd1);
    stepCycle();

    applyStimulus(5'b01001, 16'h0042, 16'h0042);
    checkOutput("branch taken", 16'(branch_taken), 16'd1);
    checkOutput("branch zero", 16'(zero), 16'd1);
    checkOutput("branch carry", 16'(carry), 16'd0);
    checkOutput("branch mem_src", 16'(mem_src), 16'd0);
    stepCycle();
    applyStimulus(5'b01001, 16'h0043, 16'h0042);
    checkOutput("branch not taken", 16'(branch_taken), 16'd0);
    checkOutput("branch diff", result, 16'h0001);
    stepCycle();

    // Multiply held in DONE by backpressure
    out_ready = 1'b0;
    applyStimulus(5'b00010, 16'h1234, 16'h0100);
    checkOutput("mul busy", 16'(in_ready), 16'd0);
    waitValid(cycles);
    checkOutput("mul latency", 16'(cycles), 16'd17);
    checkOutput("mul result", result, 16'h3400);
    checkOutput("mul hi", result_hi, 16'h0012);
    repeat (3) stepCycle();
    checkOutput("mul held valid", 16'(out_valid), 16'd1);
    checkOutput("mul held result", result, 16'h3400);
    checkOutput("mul held hi", result_hi, 16'h0012);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("mul released", 16'(in_ready), 16'd1);

    applyStimulus(5'b00010, 16'hFFFF, 16'hFFFF);
    waitValid(cycles);
    checkOutput("mul max result", result, 16'h0001);
    checkOutput("mul max hi", result_hi, 16'hFFFE);
    stepCycle();

    // Divide with a stray in_valid pulse while busy
    applyStimulus(5'b00011, 16'h0064, 16'h0007);
    repeat (3) stepCycle();
    checkOutput("div busy", 16'(in_ready), 16'd0);
    applyStimulus(5'b00000, 16'h0001, 16'h0001);
    op_a = 16'h5555;
    op_b = 16'h0003;
    waitValid(cycles);
    checkOutput("div latency", 16'(cycles), 16'd13);
    checkOutput("div quotient", result, 16'h000E);
    checkOutput("div remainder", result_hi, 16'h0002);
    checkOutput("div no dbz", 16'(div_by_zero), 16'd0);
    checkOutput("div carry", 16'(carry), 16'd0);
    stepCycle();

    applyStimulus(5'b00011, 16'h0064, 16'h0000);
    checkOutput("dbz out_valid", 16'(out_valid), 16'd1);
    checkOutput("dbz result", result, 16'hFFFF);
    checkOutput("dbz hi", result_hi, 16'h0064);
    checkOutput("dbz flag", 16'(div_by_zero), 16'd1);
    stepCycle();

    applyStimulus(5'b01110, 16'h1234, 16'h5678);
    checkOutput("illegal flag", 16'(illegal), 16'd1);
    checkOutput("illegal result", result, 16'h0000);
    checkOutput("illegal hi", result_hi, 16'h0000);
    stepCycle();

    // Reset in the middle of a multiply, after a nonzero result was left behind
    applyStimulus(5'b00111, 16'hA5A5, 16'h0000);
    stepCycle();
    applyStimulus(5'b00010, 16'h0003, 16'h0005);
    repeat (3) stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort result", result, 16'h0000);
    checkOutput("abort in_ready", 16'(in_ready), 16'd1);
    checkOutput("abort out_valid", 16'(out_valid), 16'd0);
    stepCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      stepCycle();
      if (out_valid) strayValid++;
    end
    checkOutput("abort no out_valid", 16'(strayValid), 16'd0);

    applyStimulus(5'b00010, 16'h0003, 16'h0005);
    waitValid(cycles);
    checkOutput("post-reset mul", result, 16'h000F);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
